m2vfbwrite: RTL

Frame buffer writer for the MPEG2 decoder. Takes reconstructed 8-bit pixels block by block (4 luma blocks, then Cb, then Cr, each 8x8 in raster order) and packs pixel pairs into 16-bit words. It tracks the macroblock, block, row and column counters and issues one memory write per word. Addresses come from the frame buffer address generator, which is instantiated inside this block, so the write port connects directly to the frame buffer memory arbiter.

---
 rtl/m2v_pkg.sv | 22 ++
 rtl/m2vfbagen.sv | 35 +++
 rtl/m2vfbwrite.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/m2v_pkg.sv
// Shared definitions for the MPEG2 frame buffer writer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package m2v_pkg;

    // Block order inside a macroblock: four luma blocks, then Cb, then Cr.
    localparam logic [2:0] BLK_Y0 = 3'd0;
    localparam logic [2:0] BLK_Y1 = 3'd1;
    localparam logic [2:0] BLK_Y2 = 3'd2;
    localparam logic [2:0] BLK_Y3 = 3'd3;
    localparam logic [2:0] BLK_CB = 3'd4;
    localparam logic [2:0] BLK_CR = 3'd5;

    localparam int WORDS_PER_MB = 192;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

endpackage

// File: rtl/m2vfbagen.sv
// Frame buffer address generator: maps (frame, block, mb, y, x2) to a byte address.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
// Ports: frame_i bank select, block_i block index, mbx_i/mby_i macroblock position,
//        y_i line within the 16-line tile, x2_i word column, addr_o byte address.
module m2vfbagen
    import m2v_pkg::*;
#(
    parameter int MEM_WIDTH = 21,
    parameter int MBX_WIDTH = 6,
    parameter int MBY_WIDTH = 5
) (
    input  logic                 frame_i,
    input  logic [2:0]           block_i,
    input  logic [MBX_WIDTH-1:0] mbx_i,
    input  logic [MBY_WIDTH-1:0] mby_i,
    input  logic [3:0]           y_i,
    input  logic [2:0]           x2_i,
    output logic [MEM_WIDTH-1:0] addr_o
);

    localparam int AW = MBX_WIDTH + MBY_WIDTH + 10;

    logic          chroma;
    logic [2:0]    x2_eff;
    logic [AW-1:0] raw;

    // Each macroblock is a 256-byte tile (16 lines x 16 bytes) per plane.
    // Chroma lives in its own plane; Cb/Cr words are interleaved through x2[0].
    assign chroma = (block_i >= BLK_CB);
    assign x2_eff = chroma ? {x2_i[2:1], block_i[0]} : x2_i;
    assign raw    = {frame_i, chroma, mby_i, mbx_i, y_i, x2_eff, 1'b0};
    assign addr_o = MEM_WIDTH'(raw);

endmodule

// File: rtl/m2vfbwrite.sv
// Frame buffer writer: packs 8-bit pixel pairs into 16-bit words and writes them out.
// Latency: odd pixel accepted in cycle N -> wr_req/wr_addr/wr_data registered in N+1.
// Backpressure: wr_wait holds the output word; pix_ready drops only for the odd pixel of a stalled word.
// Ports: pic_start/mbx_max/mby_max control, pix_valid/pix_data/pix_ready pixel input,
//        wr_addr/wr_data/wr_req/wr_wait write port, frame/busy/pic_done status.
module m2vfbwrite
    import m2v_pkg::*;
#(
    parameter int MEM_WIDTH = 21,
    parameter int MBX_WIDTH = 6,
    parameter int MBY_WIDTH = 5
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 pic_start,
    input  logic [MBX_WIDTH-1:0] mbx_max,
    input  logic [MBY_WIDTH-1:0] mby_max,
    input  logic                 pix_valid,
    input  logic [7:0]           pix_data,
    output logic                 pix_ready,
    output logic [MEM_WIDTH-1:0] wr_addr,
    output logic [15:0]          wr_data,
    output logic                 wr_req,
    input  logic                 wr_wait,
    output logic                 frame,
    output logic                 busy,
    output logic                 pic_done
);

    state_t                state_q, state_d;
    logic [MBX_WIDTH-1:0]  mbx_q, mbx_d;
    logic [MBY_WIDTH-1:0]  mby_q, mby_d;
    logic [2:0]            blk_q, blk_d;
    logic [2:0]            row_q, row_d;
    logic [2:0]            col_q, col_d;
    logic [7:0]            low_q;
    logic                  wr_req_q;
    logic [MEM_WIDTH-1:0]  wr_addr_q;
    logic [15:0]           wr_data_q;
    logic                  frame_q;
    logic                  pic_done_q;

    logic                  half, accept, wr_done, start, last_pix, chroma;
    logic [3:0]            ag_y;
    logic [2:0]            ag_x2;
    logic [MEM_WIDTH-1:0]  ag_addr;

    // The pixel parity within a word is simply the low column bit.
    assign half      = col_q[0];
    assign pix_ready = (state_q == ST_RUN) && !(wr_req_q && wr_wait && half);
    assign accept    = pix_valid && pix_ready;
    assign wr_done   = wr_req_q && !wr_wait;
    // A start is also refused in the pic_done cycle, where busy is still high.
    assign start     = pic_start && (state_q == ST_IDLE) && !pic_done_q;
    assign last_pix  = (col_q == 3'd7) && (row_q == 3'd7) && (blk_q == BLK_CR)
                    && (mbx_q == mbx_max) && (mby_q == mby_max);

    assign chroma = (blk_q >= BLK_CB);
    assign ag_y   = chroma ? {row_q, 1'b0} : {blk_q[1], row_q};
    assign ag_x2  = chroma ? {col_q[2:1], 1'b0} : {blk_q[0], col_q[2:1]};

    m2vfbagen #(
        .MEM_WIDTH (MEM_WIDTH),
        .MBX_WIDTH (MBX_WIDTH),
        .MBY_WIDTH (MBY_WIDTH)
    ) u_agen (
        .frame_i (frame_q),
        .block_i (blk_q),
        .mbx_i   (mbx_q),
        .mby_i   (mby_q),
        .y_i     (ag_y),
        .x2_i    (ag_x2),
        .addr_o  (ag_addr)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start)              state_d = ST_RUN;
            ST_RUN:   if (accept && last_pix) state_d = ST_FLUSH;
            ST_FLUSH: if (wr_done)            state_d = ST_IDLE;
            default:                          state_d = ST_IDLE;
        endcase
    end

    // Nested counter chain: col -> row -> block -> mbx -> mby, each wraps to 0.
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        blk_d = blk_q;
        mbx_d = mbx_q;
        mby_d = mby_q;
        if (start) begin
            col_d = '0;
            row_d = '0;
            blk_d = BLK_Y0;
            mbx_d = '0;
            mby_d = '0;
        end else if (accept) begin
            col_d = col_q + 3'd1;
            if (col_q == 3'd7) begin
                row_d = row_q + 3'd1;
                if (row_q == 3'd7) begin
                    if (blk_q == BLK_CR) begin
                        blk_d = BLK_Y0;
                        if (mbx_q == mbx_max) begin
                            mbx_d = '0;
                            mby_d = (mby_q == mby_max) ? '0 : mby_q + MBY_WIDTH'(1);
                        end else begin
                            mbx_d = mbx_q + MBX_WIDTH'(1);
                        end
                    end else begin
                        blk_d = blk_q + 3'd1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            col_q      <= '0;
            row_q      <= '0;
            blk_q      <= '0;
            mbx_q      <= '0;
            mby_q      <= '0;
            low_q      <= '0;
            wr_req_q   <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            frame_q    <= 1'b0;
            pic_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            col_q      <= col_d;
            row_q      <= row_d;
            blk_q      <= blk_d;
            mbx_q      <= mbx_d;
            mby_q      <= mby_d;
            pic_done_q <= (state_q == ST_FLUSH) && wr_done;
            if ((state_q == ST_FLUSH) && wr_done) begin
                frame_q <= ~frame_q;
            end
            if (accept && !half) begin
                low_q <= pix_data;
            end
            // A new word may load in the same cycle the previous one completes.
            if (accept && half) begin
                wr_req_q  <= 1'b1;
                wr_addr_q <= ag_addr;
                wr_data_q <= {pix_data, low_q};
            end else if (wr_done) begin
                wr_req_q  <= 1'b0;
            end
        end
    end

    assign wr_req   = wr_req_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign frame    = frame_q;
    assign pic_done = pic_done_q;
    assign busy     = (state_q != ST_IDLE) || pic_done_q;

endmodule
